dcache_responder: RTL

DCACHE_RESPONDER -- requirements
Module: dcache_responder

---
 rtl/dcache_responder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/dcache_responder.sv
`timescale 1ns/1ps
// dcache_responder
// Direct-mapped, write-through / no-write-allocate data cache sitting between
// a pipelined core's MEM stage and a simple request/ack backing memory.
// Read hits are answered combinationally in IDLE. Misses and writes stall the
// core, run one memory transaction, then spend one RESP cycle releasing it.
//
// Ports
//   clk, rst (async, active-low)
//   cpu_addr/cpu_rd/cpu_wr/cpu_wdata  : core request, held while cpu_stall=1
//   cpu_rdata/cpu_stall               : core response
//   mem_req/mem_we/mem_addr/mem_wdata : backing-memory request
//   mem_rdata/mem_ack                 : backing-memory completion
//   hit_cnt/miss_cnt                  : only with DCACHE_STATS_EN defined
//
// Build option: define DCACHE_STATS_EN to add saturating 16-bit hit/miss
// counters and their output ports.
//
// state  | meaning
// IDLE   | accept request; read hits answered here
// FILL   | read miss, fetching line from memory
// WRITE  | write-through to memory, update line on hit
// RESP   | release stall; reads return the fill register
module dcache_responder #(
  parameter int LINES = 8,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AW - IW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [DW-1:0]    data_q [LINES];

  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          op_we_q;
  logic [DW-1:0] fill_q;

  logic [IW-1:0] cpu_idx;
  logic [TW-1:0] cpu_tag;
  logic          cpu_hit;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          req_hit;

  logic          capture;
  logic          fill_we;
  logic          wr_upd;
  logic          stall_d;
  logic [DW-1:0] rdata_d;

  assign cpu_idx = cpu_addr[IW-1:0];
  assign cpu_tag = cpu_addr[AW-1:IW];
  assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  // The outstanding transaction works from the captured address, not from
  // cpu_addr, so the memory side is immune to the core's bus after capture.
  assign req_idx = addr_q[IW-1:0];
  assign req_tag = addr_q[AW-1:IW];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    fill_we = 1'b0;
    wr_upd  = 1'b0;
    stall_d = 1'b0;
    rdata_d = '0;
    unique case (state_q)
      S_IDLE: begin
        // Write takes priority over read when both are asserted.
        if (cpu_wr) begin
          stall_d = 1'b1;
          capture = 1'b1;
          state_d = S_WRITE;
        end else if (cpu_rd) begin
          if (cpu_hit) begin
            rdata_d = data_q[cpu_idx];
          end else begin
            stall_d = 1'b1;
            capture = 1'b1;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        stall_d = 1'b1;
        if (mem_ack) begin
          fill_we = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WRITE: begin
        stall_d = 1'b1;
        if (mem_ack) begin
          // No-write-allocate: only a line already holding this address changes.
          wr_upd  = req_hit;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (!op_we_q) begin
          rdata_d = fill_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Core-facing outputs are combinational from the request, so they are
  // masked by reset to stay quiet while a core holds a request during reset.
  assign cpu_stall = stall_d & rst;
  assign cpu_rdata = rst ? rdata_d : '0;

  // mem_req is decoded from state, so it drops the cycle after mem_ack and
  // immediately on reset.
  assign mem_req   = (state_q == S_FILL) || (state_q == S_WRITE);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_we_q <= 1'b0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q  <= cpu_addr;
        op_we_q <= cpu_wr;
        if (cpu_wr) begin
          wdata_q <= cpu_wdata;
        end
      end
      if (fill_we) begin
        valid_q[req_idx] <= 1'b1;
        fill_q           <= mem_rdata;
      end
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= mem_rdata;
    end else if (wr_upd) begin
      data_q[req_idx] <= wdata_q;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  logic        stat_ev;

  // One event per request seen in IDLE: a held read hit counts every cycle
  // it is presented, a miss or write counts once as it leaves IDLE.
  assign stat_ev = (state_q == S_IDLE) && (cpu_rd || cpu_wr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (stat_ev) begin
      if (cpu_hit) begin
        if (hit_cnt_q != 16'hFFFF) begin
          hit_cnt_q <= hit_cnt_q + 16'd1;
        end
      end else begin
        if (miss_cnt_q != 16'hFFFF) begin
          miss_cnt_q <= miss_cnt_q + 16'd1;
        end
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
